uart_rx_deframer: RTL and testbench

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

---
 rtl/uart_rx_deframer.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling deframer and a
// first-word-fall-through byte FIFO with sticky overflow reporting.
module uart_rx_deframer #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       ref_clk,
   input  logic       fpga_reset_n,
   input  logic       uart_RXD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overflow,
   input  logic       ovf_clr
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

   localparam logic [CntW-1:0] BitCnt  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } state_e;

   // ---------------------------------------------------------------------
   // Line synchronizer
   // ---------------------------------------------------------------------
   logic sync_q;
   logic line_q;

   always_ff @(posedge ref_clk) begin
      if (!fpga_reset_n) begin
         sync_q <= 1'b1;
         line_q <= 1'b1;
      end else begin
         sync_q <= uart_RXD;
         line_q <= sync_q;
      end
   end

   // ---------------------------------------------------------------------
   // Deframer FSM
   // ---------------------------------------------------------------------
   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      idx_q;
   logic [7:0]      shift_q;
   logic            frame_err_q;

   always_ff @(posedge ref_clk) begin
      if (!fpga_reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (!line_q) begin
                  state_q <= StStart;
                  cnt_q   <= HalfCnt;
               end
            end
            StStart: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!line_q) begin
                  state_q <= StData;
                  cnt_q   <= BitCnt;
                  idx_q   <= '0;
               end else begin
                  // Line went back high before mid-start: treat as a glitch.
                  state_q <= StIdle;
               end
            end
            StData: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  shift_q[idx_q] <= line_q;
                  cnt_q          <= BitCnt;
                  if (idx_q == 3'd7) begin
                     state_q <= StStop;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            StStop: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (line_q) begin
                  state_q <= StIdle;
               end else begin
                  frame_err_q <= 1'b1;
                  state_q     <= StWaitHigh;
               end
            end
            StWaitHigh: begin
               // Hold off until the line idles so a break reports only once.
               if (line_q) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign frame_err = frame_err_q;

   // A good stop bit pushes on the same edge the FSM returns to idle.
   logic push;
   assign push = (state_q == StStop) && (cnt_q == '0) && line_q;

   // ---------------------------------------------------------------------
   // Receive FIFO (first-word fall-through)
   // ---------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW:0]   count_q;
   logic            overflow_q;

   logic full;
   logic pop;
   logic do_write;

   assign rx_valid = (count_q != '0);
   assign full     = (count_q == FullCnt);
   assign pop      = rx_valid && rx_ready;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign do_write = push && (!full || pop);

   always_ff @(posedge ref_clk) begin
      if (!fpga_reset_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_write) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         unique case ({do_write, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push && full && !pop) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign rx_data  = mem_q[rd_ptr_q];
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 8 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_deframer;

   localparam int unsigned Cpb = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overflow;
   logic       ovf_clr;

   int n_vec = 0;
   int n_err = 0;

   int         cyc = 0;
   int         start_cyc;
   int         first_valid_cyc = -1;
   int         valid_cycles = 0;
   int         ferr_cnt = 0;
   logic [7:0] rx_q [$];

   uart_rx_deframer #(
      .CLKS_PER_BIT(Cpb),
      .FIFO_DEPTH  (4)
   ) dut (
      .ref_clk     (clk),
      .fpga_reset_n(rst_n),
      .uart_RXD    (rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe on the falling edge: what is accepted here pops on the next rise.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid && rx_ready) rx_q.push_back(rx_data);
         if (rx_valid) begin
            valid_cycles = valid_cycles + 1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (frame_err) ferr_cnt = ferr_cnt + 1;
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Start bit, 8 data bits LSB first, then stop_low bit-times of low line
   // before the final high stop bit.
   task automatic send_frame(input logic [7:0] data, input int stop_low);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      rxd = 1'b0;
      cycles(Cpb);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         cycles(Cpb);
      end
      if (stop_low > 0) begin
         rxd = 1'b0;
         cycles(stop_low * Cpb);
      end
      rxd = 1'b1;
      cycles(Cpb);
   endtask

   task automatic clear_obs();
      rx_q.delete();
      ferr_cnt        = 0;
      valid_cycles    = 0;
      first_valid_cyc = -1;
   endtask

   initial begin
      rst_n    = 1'b0;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      ovf_clr  = 1'b0;
      cycles(3);
      check_eq("rst_valid", int'(rx_valid), 0);
      check_eq("rst_ferr", int'(frame_err), 0);
      check_eq("rst_ovf", int'(overflow), 0);
      check_eq("rst_data", int'(rx_data), 0);
      rst_n = 1'b1;
      cycles(5);

      // Single byte, latency and one-cycle valid with ready held high.
      rx_ready = 1'b1;
      clear_obs();
      send_frame(8'hA5, 0);
      cycles(4);
      check_eq("a5_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check_eq("a5_data", int'(rx_q[0]), 32'hA5);
      check_eq("a5_latency", first_valid_cyc - start_cyc, 79);
      check_eq("a5_valid_len", valid_cycles, 1);
      check_eq("a5_ferr", ferr_cnt, 0);

      // Short low glitch on the idle line, then a real frame.
      clear_obs();
      @(posedge clk);
      #1 rxd = 1'b0;
      cycles(3);
      rxd = 1'b1;
      cycles(40);
      check_eq("glitch_none", rx_q.size(), 0);
      check_eq("glitch_ferr", ferr_cnt, 0);
      send_frame(8'h3C, 0);
      cycles(4);
      check_eq("3c_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check_eq("3c_data", int'(rx_q[0]), 32'h3C);

      // Break: stop bit low for 20 bit times yields a single frame error.
      clear_obs();
      send_frame(8'h55, 20);
      send_frame(8'h12, 0);
      cycles(4);
      check_eq("brk_ferr", ferr_cnt, 1);
      check_eq("brk_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check_eq("brk_data", int'(rx_q[0]), 32'h12);

      // Overflow: five bytes into a four-entry FIFO with no consumer.
      clear_obs();
      rx_ready = 1'b0;
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 0);
      cycles(2);
      check_eq("ovf_valid", int'(rx_valid), 1);
      check_eq("ovf_head", int'(rx_data), 32'h01);
      check_eq("ovf_flag", int'(overflow), 1);
      rx_ready = 1'b1;
      cycles(10);
      check_eq("ovf_drain_cnt", rx_q.size(), 4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
         check_eq($sformatf("ovf_drain%0d", i), int'(rx_q[i]), i + 1);
      end
      check_eq("ovf_sticky", int'(overflow), 1);
      ovf_clr = 1'b1;
      cycles(1);
      ovf_clr = 1'b0;
      check_eq("ovf_cleared", int'(overflow), 0);

      // Full FIFO with a pop landing on the same edge as the push.
      clear_obs();
      rx_ready = 1'b0;
      send_frame(8'h10, 0);
      send_frame(8'h20, 0);
      send_frame(8'h30, 0);
      send_frame(8'h40, 0);
      fork
         send_frame(8'h50, 0);
         begin
            repeat (79) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      cycles(2);
      check_eq("full_pp_ovf", int'(overflow), 0);
      check_eq("full_pp_popped", rx_q.size(), 1);
      check_eq("full_pp_head", int'(rx_data), 32'h20);
      rx_ready = 1'b1;
      cycles(10);
      check_eq("full_pp_total", rx_q.size(), 5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
         check_eq($sformatf("full_pp%0d", i), int'(rx_q[i]), (i + 1) * 16);
      end

      // Reset pulse during bit 4 of 0xFF abandons the frame.
      clear_obs();
      fork
         send_frame(8'hFF, 0);
         begin
            repeat (8 * 5 + 3) @(posedge clk);
            #1 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      cycles(20);
      check_eq("rst_mid_none", rx_q.size(), 0);
      send_frame(8'h81, 0);
      cycles(4);
      check_eq("rst_81_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check_eq("rst_81_data", int'(rx_q[0]), 32'h81);
      check_eq("rst_81_ferr", ferr_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
